// File: rtl/cnn_prefetch_dma_engine.sv
// cnn_prefetch_dma_engine
// Fill engine for the CNN prefetch double buffer. It claims a buffer that is
// waiting for prefetch (state 3'b001), reads its window from external memory
// in bursts, and streams 64-bit beats into the buffer.
// Optional build macro: PREFETCH_4K_SPLIT_EN. When defined, a burst never
// crosses a 4096-byte address boundary.
module cnn_prefetch_dma_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        buffer0_state,
    input  logic [2:0]        buffer1_state,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [31:0]       prefetch_length,
    output logic              prefetch_select,
    output logic              prefetch_enable,
    output logic              prefetch_write,
    output logic [DATA_W-1:0] data_in,
    output logic [31:0]       data_in_address,
    output logic              prefetch_finish,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [7:0]        rd_req_len,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_data_ready,
    output logic              busy
);

`ifdef PREFETCH_4K_SPLIT_EN
    localparam bit SPLIT_4K = 1'b1;
`else
    localparam bit SPLIT_4K = 1'b0;
`endif

    localparam logic [2:0] BUF_WAITING = 3'b001;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_ENA, S_REQ, S_DATA, S_FIN} state_t;

    state_t            state_reg;
    logic              rr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       beats_left_reg;
    logic [8:0]        burst_n_reg;
    logic [8:0]        beat_cnt_reg;

    logic [31:0]       ena_beats;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       next_beats;
    logic [8:0]        ena_n;
    logic [8:0]        cont_n;

    // Beats in the next burst: limited by MAX_BURST, by what is left, and
    // optionally by the distance to the next 4 KiB boundary.
    function automatic logic [8:0] burst_beats(input logic [11:0] offset,
                                               input logic [31:0] beats);
        logic [31:0] n;
        logic [31:0] room;
        n    = (beats > 32'(MAX_BURST)) ? 32'(MAX_BURST) : beats;
        room = (32'd4096 - {20'd0, offset}) >> 3;
        if (SPLIT_4K && (n > room))
            n = room;
        return 9'(n);
    endfunction

    // Byte length rounded up to whole 8-byte beats.
    assign ena_beats  = {3'b000, prefetch_length[31:3]} + {31'd0, |prefetch_length[2:0]};
    assign next_addr  = addr_reg + ADDR_W'({burst_n_reg, 3'b000});
    assign next_beats = beats_left_reg - {23'd0, burst_n_reg};
    assign ena_n      = burst_beats(start_address[11:0], ena_beats);
    assign cont_n     = burst_beats(next_addr[11:0], next_beats);

    // Beats pass straight through to the buffer in the cycle they are accepted.
    assign prefetch_write = (state_reg == S_DATA) && rd_data_valid;
    assign data_in        = prefetch_write ? rd_data : '0;
    assign busy           = (state_reg != S_IDLE);

    // Claim / enable / burst / finish sequencing with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            rr_reg          <= 1'b0;
            addr_reg        <= '0;
            beats_left_reg  <= '0;
            burst_n_reg     <= '0;
            beat_cnt_reg    <= '0;
            prefetch_select <= 1'b0;
            prefetch_enable <= 1'b0;
            prefetch_finish <= 1'b0;
            data_in_address <= '0;
            rd_req_valid    <= 1'b0;
            rd_req_addr     <= '0;
            rd_req_len      <= '0;
            rd_data_ready   <= 1'b0;
        end else begin
            prefetch_enable <= 1'b0;
            prefetch_finish <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (buffer0_state == BUF_WAITING && buffer1_state == BUF_WAITING) begin
                        prefetch_select <= rr_reg;
                        rr_reg          <= ~rr_reg;
                        state_reg       <= S_SEL;
                    end else if (buffer0_state == BUF_WAITING) begin
                        prefetch_select <= 1'b0;
                        state_reg       <= S_SEL;
                    end else if (buffer1_state == BUF_WAITING) begin
                        prefetch_select <= 1'b1;
                        state_reg       <= S_SEL;
                    end
                end
                S_SEL: begin
                    prefetch_enable <= 1'b1;
                    data_in_address <= '0;
                    state_reg       <= S_ENA;
                end
                S_ENA: begin
                    addr_reg       <= start_address;
                    beats_left_reg <= ena_beats;
                    if (ena_beats == 32'd0) begin
                        prefetch_finish <= 1'b1;
                        state_reg       <= S_FIN;
                    end else begin
                        rd_req_valid <= 1'b1;
                        rd_req_addr  <= start_address;
                        burst_n_reg  <= ena_n;
                        rd_req_len   <= 8'(ena_n - 9'd1);
                        state_reg    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_req_ready) begin
                        rd_req_valid  <= 1'b0;
                        rd_data_ready <= 1'b1;
                        beat_cnt_reg  <= burst_n_reg;
                        state_reg     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rd_data_valid) begin
                        data_in_address <= data_in_address + 32'd1;
                        beat_cnt_reg    <= beat_cnt_reg - 9'd1;
                        if (beat_cnt_reg == 9'd1) begin
                            rd_data_ready  <= 1'b0;
                            addr_reg       <= next_addr;
                            beats_left_reg <= next_beats;
                            if (next_beats == 32'd0) begin
                                prefetch_finish <= 1'b1;
                                state_reg       <= S_FIN;
                            end else begin
                                rd_req_valid <= 1'b1;
                                rd_req_addr  <= next_addr;
                                burst_n_reg  <= cont_n;
                                rd_req_len   <= 8'(cont_n - 9'd1);
                                state_reg    <= S_REQ;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_prefetch_dma_engine.sv
// Scoreboard bench for cnn_prefetch_dma_engine: directed fills push expected
// enable/request/write/finish events; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_cnn_prefetch_dma_engine;
    localparam int ADDR_W = 32, DATA_W = 64, MAX_BURST = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        b0, b1;
    logic [31:0]       base0 = 0, base1 = 0, len0 = 0, len1 = 0;
    logic [ADDR_W-1:0] start_address;
    logic [31:0]       prefetch_length;
    logic              prefetch_select, prefetch_enable, prefetch_write, prefetch_finish;
    logic [DATA_W-1:0] data_in;
    logic [31:0]       data_in_address;
    logic              rd_req_valid, rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [7:0]        rd_req_len;
    logic              rd_data_valid, rd_data_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    assign start_address   = prefetch_select ? base1 : base0;
    assign prefetch_length = prefetch_select ? len1 : len0;

    cnn_prefetch_dma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .buffer0_state(b0), .buffer1_state(b1),
        .start_address(start_address), .prefetch_length(prefetch_length),
        .prefetch_select(prefetch_select), .prefetch_enable(prefetch_enable),
        .prefetch_write(prefetch_write), .data_in(data_in),
        .data_in_address(data_in_address), .prefetch_finish(prefetch_finish),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .rd_data_ready(rd_data_ready), .busy(busy)
    );

    typedef struct {
        int          kind;   // 1 enable, 2 request, 3 write, 4 finish
        logic [63:0] a;
        logic [63:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {a ^ 32'hC3A5_5A3C, ~a};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_ev(input int kind, input logic [63:0] a, input logic [63:0] b, input string name);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected event a=%h b=%h, expected nothing", name, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                miscompares++;
                $display("FAIL %s: got kind=%0d a=%h b=%h, expected kind=%0d a=%h b=%h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic push_ev(input int kind, input logic [63:0] a, input logic [63:0] b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    // One request followed by its beats, data tied to the beat's byte address.
    task automatic push_burst(input logic [31:0] addr, input int len, input int first_idx);
        push_ev(2, 64'(addr), 64'(len));
        for (int k = 0; k <= len; k++)
            push_ev(3, 64'(first_idx + k), pat(addr + 32'(8 * k)));
    endtask

    // Buffer controller model: 001 on load, 010 after enable, 011 after finish.
    int load0 = 0, load1 = 0, seen0 = 0, seen1 = 0;
    initial begin
        logic en_s, fin_s, sel_s;
        b0 = 3'b000; b1 = 3'b000;
        forever begin
            @(negedge clk);
            en_s = prefetch_enable; fin_s = prefetch_finish; sel_s = prefetch_select;
            @(posedge clk); #1;
            if (!rst) begin
                b0 = 3'b000; b1 = 3'b000;
            end else begin
                if (en_s) begin
                    if (sel_s) b1 = 3'b010; else b0 = 3'b010;
                end
                if (fin_s) begin
                    if (sel_s) b1 = 3'b011; else b0 = 3'b011;
                end
                if (load0 != seen0) begin b0 = 3'b001; seen0 = load0; end
                if (load1 != seen1) begin b1 = 3'b001; seen1 = load1; end
            end
        end
    end

    // Memory responder: optional request stall, then back-to-back beats.
    int req_stall = 0;
    initial begin
        int          mstate, stall_cnt, m_left;
        logic [31:0] m_addr;
        mstate = 0; stall_cnt = 0; m_left = 0; m_addr = '0;
        rd_req_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                mstate = 0; stall_cnt = 0;
                rd_req_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
            end else begin
                case (mstate)
                    0: if (rd_req_valid && !rd_req_ready) begin
                        if (stall_cnt >= req_stall) begin
                            rd_req_ready = 1'b1;
                            m_addr = rd_req_addr;
                            m_left = int'(rd_req_len) + 1;
                            stall_cnt = 0;
                            mstate = 1;
                        end else begin
                            stall_cnt++;
                        end
                    end
                    1: begin
                        rd_req_ready = 1'b0;
                        rd_data_valid = 1'b1;
                        rd_data = pat(m_addr);
                        mstate = 2;
                    end
                    default: begin
                        m_addr = m_addr + 32'd8;
                        m_left--;
                        if (m_left == 0) begin
                            rd_data_valid = 1'b0; rd_data = '0; mstate = 0;
                        end else begin
                            rd_data = pat(m_addr);
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT event and checks timing rules.
    initial begin
        int          cyc, en_cyc, wr_cyc;
        bit          wait_req, any_wr, prev_v;
        logic [31:0] prev_a;
        logic [7:0]  prev_l;
        cyc = 0; en_cyc = 0; wr_cyc = 0; wait_req = 0; any_wr = 0; prev_v = 0;
        prev_a = '0; prev_l = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                wait_req = 0; any_wr = 0; prev_v = 0;
            end else begin
                if (prefetch_enable) begin
                    check_ev(1, 64'(prefetch_select), 64'd0, "enable");
                    en_cyc = cyc; wait_req = 1; any_wr = 0;
                end
                if (rd_req_valid && wait_req) begin
                    cmp("req_latency", 64'(cyc), 64'(en_cyc + 1));
                    wait_req = 0;
                end
                if (rd_req_valid && prev_v) begin
                    cmp("req_addr_hold", 64'(rd_req_addr), 64'(prev_a));
                    cmp("req_len_hold", 64'(rd_req_len), 64'(prev_l));
                end
                if (rd_req_valid && rd_req_ready)
                    check_ev(2, 64'(rd_req_addr), 64'(rd_req_len), "request");
                if (prefetch_write) begin
                    check_ev(3, 64'(data_in_address), data_in, "write");
                    wr_cyc = cyc; any_wr = 1;
                end
                if (prefetch_finish) begin
                    check_ev(4, 64'(prefetch_select), 64'd0, "finish");
                    cmp("finish_timing", 64'(cyc), 64'((any_wr ? wr_cyc : en_cyc) + 1));
                    wait_req = 0;
                end
                prev_v = rd_req_valid && !rd_req_ready;
                prev_a = rd_req_addr;
                prev_l = rd_req_len;
            end
        end
    end

    task automatic wait_drain(input string name, input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin done = 1; break; end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s: timeout with %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        $display("%s: done, %0d vectors so far, %0d miscompares", name, vectors, miscompares);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_select"}, 64'(prefetch_select), 64'd0);
        cmp({tag, "_enable"}, 64'(prefetch_enable), 64'd0);
        cmp({tag, "_write"}, 64'(prefetch_write), 64'd0);
        cmp({tag, "_data_in"}, data_in, 64'd0);
        cmp({tag, "_data_in_address"}, 64'(data_in_address), 64'd0);
        cmp({tag, "_finish"}, 64'(prefetch_finish), 64'd0);
        cmp({tag, "_req_valid"}, 64'(rd_req_valid), 64'd0);
        cmp({tag, "_req_addr"}, 64'(rd_req_addr), 64'd0);
        cmp({tag, "_req_len"}, 64'(rd_req_len), 64'd0);
        cmp({tag, "_data_ready"}, 64'(rd_data_ready), 64'd0);
        cmp({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit hit;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Both buffers waiting: buffer0 (two 16-beat bursts) then buffer1.
        push_ev(1, 64'd0, 64'd0);
        push_burst(32'h0000_1000, 15, 0);
        push_burst(32'h0000_1080, 15, 16);
        push_ev(4, 64'd0, 64'd0);
        push_ev(1, 64'd1, 64'd0);
        push_burst(32'h0000_3000, 2, 0);
        push_ev(4, 64'd1, 64'd0);
        base0 = 32'h0000_1000; len0 = 32'd256;
        base1 = 32'h0000_3000; len1 = 32'd24;
        @(posedge clk); #1;
        load0++; load1++;
        wait_drain("both_buffers", 3000);

        // Zero length: enable then finish, no memory traffic.
        push_ev(1, 64'd0, 64'd0);
        push_ev(4, 64'd0, 64'd0);
        base0 = 32'h0000_7000; len0 = 32'd0;
        @(posedge clk); #1;
        load0++;
        wait_drain("len_zero", 200);

        // 20 bytes -> 3 beats, request stalled for several cycles.
        req_stall = 5;
        push_ev(1, 64'd1, 64'd0);
        push_burst(32'h0000_5008, 2, 0);
        push_ev(4, 64'd1, 64'd0);
        base1 = 32'h0000_5008; len1 = 32'd20;
        @(posedge clk); #1;
        load1++;
        wait_drain("len20_stall", 300);
        req_stall = 0;

        // Window straddling a 4 KiB boundary.
        push_ev(1, 64'd0, 64'd0);
`ifdef PREFETCH_4K_SPLIT_EN
        push_burst(32'h0000_0FF0, 1, 0);
        push_burst(32'h0000_1000, 5, 2);
`else
        push_burst(32'h0000_0FF0, 7, 0);
`endif
        push_ev(4, 64'd0, 64'd0);
        base0 = 32'h0000_0FF0; len0 = 32'd64;
        @(posedge clk); #1;
        load0++;
        wait_drain("boundary_4k", 300);

        // Reset in the middle of a burst into buffer1.
        push_ev(1, 64'd1, 64'd0);
        push_burst(32'h0000_2000, 15, 0);
        push_burst(32'h0000_2080, 15, 16);
        push_ev(4, 64'd1, 64'd0);
        base1 = 32'h0000_2000; len1 = 32'd256;
        @(posedge clk); #1;
        load1++;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (prefetch_write && data_in_address == 32'd5) begin hit = 1; break; end
        end
        cmp("reach_mid_data", 64'(hit), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("post_reset_busy", 64'(busy), 64'd0);
            cmp("post_reset_req_valid", 64'(rd_req_valid), 64'd0);
        end
        $display("mid_reset: done, %0d vectors so far, %0d miscompares", vectors, miscompares);

        // Recovery: a single-beat fill after reset.
        push_ev(1, 64'd0, 64'd0);
        push_burst(32'h0000_0000, 0, 0);
        push_ev(4, 64'd0, 64'd0);
        base0 = 32'h0000_0000; len0 = 32'd8;
        @(posedge clk); #1;
        load0++;
        wait_drain("recovery", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
